teclado_pin: RTL and testbench
==============================

TECLADO_PIN -- requirements
Module: teclado_pin

Interface
REQ-001 Parameter TIMEOUT, default 50; idle cycles after which a partial entry is discarded.
REQ-002 Clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Tecla  input  4  key code: 0x0-0x9 digits, 0xA borrar (clear), 0xB enter, 0xC-0xF unused.
REQ-005 TeclaValida  input  1  key-pressed level; may stay high for many cycles per press.
REQ-006 Vehiculo  input  1  vehicle present at gate; entry is accepted only while high.
REQ-007 Pin  output  8  assembled BCD PIN, first digit in [7:4], second digit in [3:0].
REQ-008 enterPin  output  1  one-cycle strobe; Pin is valid and stable while high.
REQ-009 Digitos  output  2  number of digits currently held (0, 1 or 2).
REQ-010 ErrorFormato  output  1  one-cycle pulse when enter is pressed with fewer than 2 digits.

Function
REQ-011 A key event is a 0->1 transition of TeclaValida sampled on Clk; a held level produces exactly one event.
REQ-012 A key event is acted on in the first cycle after the edge is sampled (1-cycle latency to state, Pin, Digitos and strobes).
REQ-013 The FSM has four states: VACIO (0 digits), UN_DIGITO, DOS_DIGITOS, ENVIO.
REQ-014 VACIO + digit d -> UN_DIGITO; Pin[7:4]=d, Pin[3:0]=0, Digitos=1.
REQ-015 UN_DIGITO + digit d -> DOS_DIGITOS; Pin[3:0]=d, Digitos=2.
REQ-016 DOS_DIGITOS + digit: ignored; no change to Pin or Digitos.
REQ-017 DOS_DIGITOS + enter -> ENVIO; enterPin=1 for exactly one cycle, then the FSM returns to VACIO with Digitos=0.
REQ-018 After ENVIO, Pin keeps the sent value until the next accepted first digit overwrites it.
REQ-019 Enter in VACIO or UN_DIGITO: ErrorFormato=1 for one cycle, FSM -> VACIO, Digitos=0, Pin=0, no enterPin.
REQ-020 Borrar in any state except ENVIO: FSM -> VACIO, Pin=0, Digitos=0.
REQ-021 Codes 0xC-0xF produce no state or output change.
REQ-022 Key events in ENVIO are dropped.
REQ-023 The idle counter resets on every accepted key event and counts only in UN_DIGITO or DOS_DIGITOS; at TIMEOUT cycles: FSM -> VACIO, Pin=0, Digitos=0, no strobes.
REQ-024 Vehiculo low forces VACIO next cycle (Pin=0, Digitos=0), masks all key events, and keeps enterPin and ErrorFormato low.
REQ-025 Vehiculo falling in the same cycle as an enter event: Vehiculo wins, no enterPin.
REQ-026 enterPin and ErrorFormato are never high in the same cycle.

Reset
REQ-027 Reset high at a rising edge: FSM=VACIO, Pin=8'h00, Digitos=0, enterPin=0, ErrorFormato=0, idle counter=0, edge-detect register=0.
REQ-028 Reset takes priority over every input; a reset mid-entry discards the partial PIN with no strobe.
REQ-029 A TeclaValida level already high when Reset falls does not produce a key event.

Structure
REQ-030 A shared package holds the key codes (borrar 0xA, enter 0xB), the FSM state encoding and the TIMEOUT default.
REQ-031 Edge detection lives in one sub-module, detector_flanco (1-bit rising-edge pulse, synchronous reset).
REQ-032 The idle counter width is clog2(TIMEOUT+1).

Verification
REQ-033 Vehiculo=1, keys 1 then 0, then enter -> Pin=8'h10, enterPin high exactly 1 cycle, Digitos back to 0.
REQ-034 Vehiculo=1, key 7 then enter -> ErrorFormato 1 cycle, no enterPin, Pin=8'h00.
REQ-035 Keys 1, 0, 9 then enter -> the third digit is ignored and enterPin is sent with Pin=8'h10; TeclaValida held for 5 cycles -> single event.
REQ-036 Key 4, then 50 idle cycles -> Digitos=0 and Pin=0 at cycle 50; a following enter raises ErrorFormato.
REQ-037 Keys 1, 0, then Vehiculo dropped in the same cycle as the enter edge -> no enterPin, Pin=0; borrar after 1 digit -> Digitos=0.
REQ-038 Reset asserted after the first digit -> all outputs zero next cycle, with TeclaValida held high through the reset release producing no event.

Source files
------------

// File: rtl/teclado_pin_pkg.sv
// Shared definitions for the gate PIN keypad: key codes, FSM state encoding
// and the default idle timeout.
package teclado_pin_pkg;

  localparam logic [3:0] TECLA_BORRAR = 4'hA;
  localparam logic [3:0] TECLA_ENTER  = 4'hB;
  localparam int         TIMEOUT_DEF  = 50;

  typedef enum logic [1:0] {
    VACIO       = 2'd0,
    UN_DIGITO   = 2'd1,
    DOS_DIGITOS = 2'd2,
    ENVIO       = 2'd3
  } estado_t;

  function automatic logic es_digito(input logic [3:0] tecla);
    return (tecla <= 4'd9);
  endfunction

endpackage

// File: rtl/teclado_pin_detector_flanco.sv
// Rising-edge pulse generator for the key-pressed level. A level that is
// already high while reset is asserted is locked out until it drops.
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic nivel,
  output logic pulso
);

  logic previo;
  logic bloqueo;

  always_ff @(posedge clk) begin
    if (rst) begin
      previo  <= 1'b0;
      bloqueo <= nivel;
    end else begin
      previo <= nivel;
      if (!nivel) bloqueo <= 1'b0;
    end
  end

  assign pulso = nivel & ~previo & ~bloqueo;

endmodule

// File: rtl/teclado_pin.sv
// Two-digit BCD PIN entry keypad for a vehicle gate: collects digits,
// strobes the PIN on enter, flags short entries and drops stale input.
module teclado_pin
  import teclado_pin_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Tecla,
  input  logic       TeclaValida,
  input  logic       Vehiculo,
  output logic [7:0] Pin,
  output logic       enterPin,
  output logic [1:0] Digitos,
  output logic       ErrorFormato
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(TIMEOUT - 1);

  estado_t          estado, estado_n;
  logic [7:0]       pin_q, pin_n;
  logic [1:0]       digitos_q, digitos_n;
  logic             enter_q, enter_n;
  logic             error_q, error_n;
  logic [CNT_W-1:0] cuenta, cuenta_n;
  logic             evento;

  detector_flanco u_flanco (
    .clk   (Clk),
    .rst   (Reset),
    .nivel (TeclaValida),
    .pulso (evento)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      estado    <= VACIO;
      pin_q     <= 8'h00;
      digitos_q <= 2'd0;
      enter_q   <= 1'b0;
      error_q   <= 1'b0;
      cuenta    <= '0;
    end else begin
      estado    <= estado_n;
      pin_q     <= pin_n;
      digitos_q <= digitos_n;
      enter_q   <= enter_n;
      error_q   <= error_n;
      cuenta    <= cuenta_n;
    end
  end

  always_comb begin
    estado_n  = estado;
    pin_n     = pin_q;
    digitos_n = digitos_q;
    enter_n   = 1'b0;
    error_n   = 1'b0;
    cuenta_n  = '0;

    // A missing vehicle overrides everything, including a same-cycle enter.
    if (!Vehiculo) begin
      estado_n  = VACIO;
      pin_n     = 8'h00;
      digitos_n = 2'd0;
    end else if (estado == ENVIO) begin
      // Pin is kept after sending; only the digit count is cleared.
      estado_n  = VACIO;
      digitos_n = 2'd0;
    end else if (evento) begin
      if (es_digito(Tecla)) begin
        case (estado)
          VACIO: begin
            estado_n  = UN_DIGITO;
            pin_n     = {Tecla, 4'h0};
            digitos_n = 2'd1;
          end
          UN_DIGITO: begin
            estado_n  = DOS_DIGITOS;
            pin_n     = {pin_q[7:4], Tecla};
            digitos_n = 2'd2;
          end
          default: ;
        endcase
      end else if (Tecla == TECLA_BORRAR) begin
        estado_n  = VACIO;
        pin_n     = 8'h00;
        digitos_n = 2'd0;
      end else if (Tecla == TECLA_ENTER) begin
        if (estado == DOS_DIGITOS) begin
          estado_n = ENVIO;
          enter_n  = 1'b1;
        end else begin
          estado_n  = VACIO;
          pin_n     = 8'h00;
          digitos_n = 2'd0;
          error_n   = 1'b1;
        end
      end
    end else if (estado == UN_DIGITO || estado == DOS_DIGITOS) begin
      if (cuenta == CNT_FIN) begin
        estado_n  = VACIO;
        pin_n     = 8'h00;
        digitos_n = 2'd0;
      end else begin
        cuenta_n = cuenta + 1'b1;
      end
    end
  end

  assign Pin          = pin_q;
  assign Digitos      = digitos_q;
  assign enterPin     = enter_q;
  assign ErrorFormato = error_q;

endmodule

// File: tb/tb_teclado_pin.sv
// Directed bench for teclado_pin: entry, short-entry error, ignored third
// digit, idle timeout, vehicle loss, clear and reset with a held key.
module tb_teclado_pin;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Tecla = 4'h0;
  logic       TeclaValida = 1'b0;
  logic       Vehiculo = 1'b1;
  logic [7:0] Pin;
  logic       enterPin;
  logic [1:0] Digitos;
  logic       ErrorFormato;

  int checks = 0;
  int errors = 0;

  teclado_pin #(.TIMEOUT(50)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Tecla        (Tecla),
    .TeclaValida  (TeclaValida),
    .Vehiculo     (Vehiculo),
    .Pin          (Pin),
    .enterPin     (enterPin),
    .Digitos      (Digitos),
    .ErrorFormato (ErrorFormato)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    Tecla = code;
    TeclaValida = 1'b1;
    tick();
  endtask

  task automatic release_key();
    TeclaValida = 1'b0;
    tick();
  endtask

  task automatic expect_out(input string tag, input logic [7:0] pin, input logic [1:0] dig,
                            input logic ent, input logic err);
    check({tag, "_pin"}, Pin, pin);
    check({tag, "_dig"}, {6'd0, Digitos}, {6'd0, dig});
    check({tag, "_ent"}, {7'd0, enterPin}, {7'd0, ent});
    check({tag, "_err"}, {7'd0, ErrorFormato}, {7'd0, err});
  endtask

  initial begin
    tick();
    tick();
    expect_out("reset", 8'h00, 2'd0, 1'b0, 1'b0);
    Reset = 1'b0;
    tick();
    expect_out("idle", 8'h00, 2'd0, 1'b0, 1'b0);

    // Normal two-digit entry
    press(4'h1);   expect_out("e1_d1", 8'h10, 2'd1, 1'b0, 1'b0);
    release_key();
    press(4'h0);   expect_out("e1_d2", 8'h10, 2'd2, 1'b0, 1'b0);
    release_key();
    press(4'hB);   expect_out("e1_ent", 8'h10, 2'd2, 1'b1, 1'b0);
    release_key(); expect_out("e1_post", 8'h10, 2'd0, 1'b0, 1'b0);

    // Enter with one digit
    press(4'h7);   expect_out("e2_d1", 8'h70, 2'd1, 1'b0, 1'b0);
    release_key();
    press(4'hB);   expect_out("e2_err", 8'h00, 2'd0, 1'b0, 1'b1);
    release_key(); expect_out("e2_post", 8'h00, 2'd0, 1'b0, 1'b0);

    // Held key yields one event; unused code and clear
    press(4'h3);
    for (int i = 0; i < 4; i++) tick();
    expect_out("hold5", 8'h30, 2'd1, 1'b0, 1'b0);
    release_key();
    press(4'hC);   expect_out("unused", 8'h30, 2'd1, 1'b0, 1'b0);
    release_key();
    press(4'hA);   expect_out("borrar", 8'h00, 2'd0, 1'b0, 1'b0);
    release_key();

    // Third digit ignored, held enter strobes once
    press(4'h1); release_key();
    press(4'h0); release_key();
    press(4'h9);
    for (int i = 0; i < 4; i++) tick();
    expect_out("e3_d3", 8'h10, 2'd2, 1'b0, 1'b0);
    release_key();
    press(4'hB);   expect_out("e3_ent", 8'h10, 2'd2, 1'b1, 1'b0);
    tick();        expect_out("e3_hold", 8'h10, 2'd0, 1'b0, 1'b0);
    tick();        expect_out("e3_hold2", 8'h10, 2'd0, 1'b0, 1'b0);
    release_key();

    // Idle timeout: 50 cycles after the digit takes effect
    press(4'h4);   expect_out("to_d1", 8'h40, 2'd1, 1'b0, 1'b0);
    TeclaValida = 1'b0;
    for (int i = 0; i < 49; i++) tick();
    expect_out("to_49", 8'h40, 2'd1, 1'b0, 1'b0);
    tick();        expect_out("to_50", 8'h00, 2'd0, 1'b0, 1'b0);
    press(4'hB);   expect_out("to_err", 8'h00, 2'd0, 1'b0, 1'b1);
    release_key();

    // Vehicle lost in the same cycle as enter
    press(4'h1); release_key();
    press(4'h0); release_key();
    Tecla = 4'hB;
    TeclaValida = 1'b1;
    Vehiculo = 1'b0;
    tick();        expect_out("veh_ent", 8'h00, 2'd0, 1'b0, 1'b0);
    Vehiculo = 1'b1;
    release_key(); expect_out("veh_post", 8'h00, 2'd0, 1'b0, 1'b0);

    // Reset mid-entry with key held through release
    press(4'h5);   expect_out("rst_d1", 8'h50, 2'd1, 1'b0, 1'b0);
    Reset = 1'b1;
    tick();        expect_out("rst_mid", 8'h00, 2'd0, 1'b0, 1'b0);
    Reset = 1'b0;
    tick();        expect_out("rst_rel", 8'h00, 2'd0, 1'b0, 1'b0);
    tick();        expect_out("rst_rel2", 8'h00, 2'd0, 1'b0, 1'b0);
    release_key();
    press(4'h6);   expect_out("rst_after", 8'h60, 2'd1, 1'b0, 1'b0);
    release_key();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
